// File: rtl/raycast_pkg.sv
// raycast_pkg: shared sizes, clamp/timeout limits and scheduler state encodings.
package raycast_pkg;
  localparam int NUM_COLS = 160;
  localparam int COL_W = 8;
  localparam int HEIGHT_W = 7;
  localparam int WDOG_W = 10;
  localparam int FIFO_DEPTH = 4;
  localparam logic [HEIGHT_W-1:0] MAX_HEIGHT = 7'd120;
  localparam logic [WDOG_W-1:0] TIMEOUT = 10'd1023;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_NEXT  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;
endpackage

// File: rtl/slice_result_fifo.sv
// slice_result_fifo: synchronous FIFO whose head is read straight from the storage flops.
module slice_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 15
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign head = mem_q[rd_q];
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = push_data;
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/slice_column_scheduler.sv
// slice_column_scheduler: walks a frame's columns through the slice calculator and queues clamped heights for the drawer.
module slice_column_scheduler
  import raycast_pkg::*;
(
  input  logic                clock,
  input  logic                resetn,
  input  logic                frame_start,
  input  logic [12:0]         playerX_in,
  input  logic [12:0]         playerY_in,
  input  logic [9:0]          angle_X_in,
  input  logic [9:0]          angle_Y_in,
  output logic [12:0]         calc_playerX,
  output logic [12:0]         calc_playerY,
  output logic [9:0]          calc_angle_X,
  output logic [9:0]          calc_angle_Y,
  output logic [COL_W-1:0]    calc_column,
  output logic                calc_begin,
  input  logic                calc_end,
  input  logic [HEIGHT_W-1:0] calc_slice_size,
  output logic                draw_valid,
  input  logic                draw_ready,
  output logic [COL_W-1:0]    draw_column,
  output logic [HEIGHT_W-1:0] draw_height,
  output logic                frame_busy,
  output logic                frame_done,
  output logic                timeout_err
);
  state_t state_q, state_d;
  logic [COL_W-1:0] column_q, column_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [45:0] pose_q, pose_d;
  logic calc_begin_q, calc_begin_d, busy_q, busy_d, done_q, done_d, terr_q, terr_d;
  logic push, full, empty;
  logic [HEIGHT_W-1:0] push_height;
  always_comb begin
    state_d = state_q;
    column_d = column_q;
    wdog_d = wdog_q;
    pose_d = pose_q;
    calc_begin_d = 1'b0;
    busy_d = busy_q;
    done_d = 1'b0;
    terr_d = terr_q;
    push = 1'b0;
    push_height = '0;
    case (state_q)
      S_IDLE: if (frame_start) begin
        state_d = S_ISSUE;
        pose_d = {playerX_in, playerY_in, angle_X_in, angle_Y_in};
        column_d = '0;
        terr_d = 1'b0;
        busy_d = 1'b1;
      end
      S_ISSUE: if (!full) begin
        calc_begin_d = 1'b1;
        wdog_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = wdog_q + 1'b1;
        // a result arriving on the expiry cycle still counts as a real answer
        if (calc_end || wdog_q == TIMEOUT) begin
          push = 1'b1;
          push_height = !calc_end ? '0 : calc_slice_size > MAX_HEIGHT ? MAX_HEIGHT : calc_slice_size;
          terr_d = terr_q | ~calc_end;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        state_d = column_q == LAST_COL ? S_DRAIN : S_ISSUE;
        column_d = column_q == LAST_COL ? column_q : column_q + 1'b1;
      end
      S_DRAIN: if (empty) begin
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      column_q <= '0;
      wdog_q <= '0;
      pose_q <= '0;
      calc_begin_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      terr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      column_q <= column_d;
      wdog_q <= wdog_d;
      pose_q <= pose_d;
      calc_begin_q <= calc_begin_d;
      busy_q <= busy_d;
      done_q <= done_d;
      terr_q <= terr_d;
    end
  end
  slice_result_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(COL_W + HEIGHT_W)) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (push),
    .push_data ({column_q, push_height}),
    .pop       (draw_valid & draw_ready),
    .head      ({draw_column, draw_height}),
    .full      (full),
    .empty     (empty)
  );
  assign draw_valid = ~empty;
  assign {calc_playerX, calc_playerY, calc_angle_X, calc_angle_Y} = pose_q;
  assign calc_column = column_q;
  assign calc_begin = calc_begin_q;
  assign frame_busy = busy_q;
  assign frame_done = done_q;
  assign timeout_err = terr_q;
endmodule
